// File: rtl/regfile_wb_arbiter_if.sv
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Writeback bus shared by the two requesters, the read-address
//               hazard check and the Reg_File write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              v0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] data0;
  logic              rdy0;
  logic              v1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data1;
  logic              rdy1;
  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic              busy1;
  logic              busy2;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD;
  logic              WE;

  modport slave (
    input  v0, addr0, data0, v1, addr1, data1, A1, A2,
    output rdy0, rdy1, busy1, busy2, A3, WD, WE
  );

  modport master (
    output v0, addr0, data0, v1, addr1, data1, A1, A2,
    input  rdy0, rdy1, busy1, busy2, A3, WD, WE
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin arbiter sharing one Reg_File write port between
//               two 1-entry writeback slots, with RAW hazard flags on A1/A2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int ZERO_DROP = 1
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            flush_i,
  regfile_wb_arbiter_if.slave  bus
);

  localparam logic [ADDR_W-1:0] c_ZERO_ADDR = '0;

  // Per-slot request inputs gathered into indexable form
  logic [1:0]        w_v;
  logic [ADDR_W-1:0] w_addr [2];
  logic [DATA_W-1:0] w_data [2];

  assign w_v       = {bus.v1, bus.v0};
  assign w_addr[0] = bus.addr0;
  assign w_addr[1] = bus.addr1;
  assign w_data[0] = bus.data0;
  assign w_data[1] = bus.data1;

  // Slot state
  logic [1:0]        sv_q, sv_d;
  logic [ADDR_W-1:0] sa_q [2];
  logic [ADDR_W-1:0] sa_d [2];
  logic [DATA_W-1:0] sd_q [2];
  logic [DATA_W-1:0] sd_d [2];

  // Output stage and arbitration history
  logic              last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              we_q, we_d;

  logic [1:0]        w_gnt;
  logic [1:0]        w_rdy;
  logic [1:0]        w_acc;

  // last_gnt_q==1 means slot 1 went last, so slot 0 wins a tie
  assign w_gnt[0] = sv_q[0] & (~sv_q[1] |  last_gnt_q);
  assign w_gnt[1] = sv_q[1] & (~sv_q[0] | ~last_gnt_q);

  generate
    for (genvar i = 0; i < 2; i++) begin : g_slot
      assign w_rdy[i] = ~sv_q[i] | w_gnt[i];
      assign w_acc[i] = w_v[i] & w_rdy[i];

      always_comb begin
        sv_d[i] = sv_q[i];
        sa_d[i] = sa_q[i];
        sd_d[i] = sd_q[i];
        if (flush_i) begin
          sv_d[i] = 1'b0;
        end else if (w_acc[i]) begin
          sv_d[i] = 1'b1;
          sa_d[i] = w_addr[i];
          sd_d[i] = w_data[i];
        end else if (w_gnt[i]) begin
          sv_d[i] = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sv_q[i] <= 1'b0;
          sa_q[i] <= '0;
          sd_q[i] <= '0;
        end else begin
          sv_q[i] <= sv_d[i];
          sa_q[i] <= sa_d[i];
          sd_q[i] <= sd_d[i];
        end
      end
    end
  endgenerate

  assign bus.rdy0 = w_rdy[0];
  assign bus.rdy1 = w_rdy[1];

  // Output stage: capture the granted slot, suppressing WE for r0 if enabled
  always_comb begin
    a3_d       = a3_q;
    wd_d       = wd_q;
    we_d       = 1'b0;
    last_gnt_d = last_gnt_q;
    if (!flush_i) begin
      if (w_gnt[0]) begin
        a3_d       = sa_q[0];
        wd_d       = sd_q[0];
        we_d       = !((ZERO_DROP != 0) && (sa_q[0] == c_ZERO_ADDR));
        last_gnt_d = 1'b0;
      end else if (w_gnt[1]) begin
        a3_d       = sa_q[1];
        wd_d       = sd_q[1];
        we_d       = !((ZERO_DROP != 0) && (sa_q[1] == c_ZERO_ADDR));
        last_gnt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= 1'b1;
      a3_q       <= '0;
      wd_q       <= '0;
      we_q       <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      a3_q       <= a3_d;
      wd_q       <= wd_d;
      we_q       <= we_d;
    end
  end

  assign bus.A3 = a3_q;
  assign bus.WD = wd_q;
  assign bus.WE = we_q;

  // Hazard check: any pending or committing write to the read address
  logic [ADDR_W-1:0] w_ra   [2];
  logic [1:0]        w_busy;

  assign w_ra[0] = bus.A1;
  assign w_ra[1] = bus.A2;

  generate
    for (genvar k = 0; k < 2; k++) begin : g_hazard
      logic w_addr_ok;
      assign w_addr_ok = (ZERO_DROP == 0) || (w_ra[k] != c_ZERO_ADDR);
      assign w_busy[k] = w_addr_ok &&
                         ((sv_q[0] && (sa_q[0] == w_ra[k])) ||
                          (sv_q[1] && (sa_q[1] == w_ra[k])) ||
                          (we_q    && (a3_q    == w_ra[k])));
    end
  endgenerate

  assign bus.busy1 = w_busy[0];
  assign bus.busy2 = w_busy[1];

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed bench for regfile_wb_arbiter with hand-computed
//               expectations checked by immediate assertions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk;
  logic rst_n;
  logic flush;

  int n_vec;
  int n_err;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_arbiter #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .ZERO_DROP (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.v0 = 1'b0; bus.addr0 = '0; bus.data0 = '0;
    bus.v1 = 1'b0; bus.addr1 = '0; bus.data1 = '0;
    bus.A1 = '0;   bus.A2 = '0;
    flush  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    idle_inputs();
    #1;
    step();
    do_reset();

    // Reset state
    chk("rst_we",   64'(bus.WE),   64'd0);
    chk("rst_a3",   64'(bus.A3),   64'd0);
    chk("rst_wd",   64'(bus.WD),   64'd0);
    chk("rst_rdy0", 64'(bus.rdy0), 64'd1);
    chk("rst_rdy1", 64'(bus.rdy1), 64'd1);

    // T1: single write, visible two edges later for one cycle
    bus.v0 = 1'b1; bus.addr0 = 5'd3; bus.data0 = 32'hDEADBEEF;
    #1;
    chk("t1_rdy0", 64'(bus.rdy0), 64'd1);
    step();
    bus.v0 = 1'b0; bus.data0 = 32'h0;
    chk("t1_we_n1", 64'(bus.WE), 64'd0);
    step();
    chk("t1_we_n2", 64'(bus.WE), 64'd1);
    chk("t1_a3",    64'(bus.A3), 64'd3);
    chk("t1_wd",    64'(bus.WD), 64'hDEADBEEF);
    step();
    chk("t1_we_n3", 64'(bus.WE), 64'd0);

    // T2: simultaneous requests, req0 wins first
    do_reset();
    bus.v0 = 1'b1; bus.addr0 = 5'd4; bus.data0 = 32'h0000_0444;
    bus.v1 = 1'b1; bus.addr1 = 5'd9; bus.data1 = 32'h0000_0999;
    step();
    bus.v0 = 1'b0; bus.v1 = 1'b0;
    #1;
    chk("t2_rdy1_blk", 64'(bus.rdy1), 64'd0);
    chk("t2_rdy0",     64'(bus.rdy0), 64'd1);
    step();
    chk("t2_we1", 64'(bus.WE), 64'd1);
    chk("t2_a3a", 64'(bus.A3), 64'd4);
    chk("t2_wda", 64'(bus.WD), 64'h444);
    step();
    chk("t2_we2", 64'(bus.WE), 64'd1);
    chk("t2_a3b", 64'(bus.A3), 64'd9);
    chk("t2_wdb", 64'(bus.WD), 64'h999);
    step();
    chk("t2_we3", 64'(bus.WE), 64'd0);

    // T3: both held valid for 8 edges; grants alternate with no WE gaps
    do_reset();
    bus.v0 = 1'b1; bus.addr0 = 5'd10; bus.data0 = 32'hA0A0_0000;
    bus.v1 = 1'b1; bus.addr1 = 5'd11; bus.data1 = 32'hB1B1_0000;
    step();
    for (int e = 2; e <= 10; e++) begin
      if (e == 9) begin
        bus.v0 = 1'b0; bus.v1 = 1'b0;
        #1;
      end
      step();
      chk($sformatf("t3_we_e%0d", e), 64'(bus.WE), 64'd1);
      chk($sformatf("t3_a3_e%0d", e), 64'(bus.A3), (e % 2 == 0) ? 64'd10 : 64'd11);
    end
    step();
    chk("t3_we_end", 64'(bus.WE), 64'd0);

    // T4: write to r0 handshakes but never raises WE
    do_reset();
    bus.v0 = 1'b1; bus.addr0 = 5'd0; bus.data0 = 32'h1234; bus.A1 = 5'd0;
    #1;
    chk("t4_rdy0", 64'(bus.rdy0), 64'd1);
    step();
    bus.v0 = 1'b0;
    #1;
    chk("t4_busy1_a", 64'(bus.busy1), 64'd0);
    step();
    chk("t4_we",      64'(bus.WE),    64'd0);
    chk("t4_busy1_b", 64'(bus.busy1), 64'd0);
    chk("t4_rdy0_b",  64'(bus.rdy0),  64'd1);

    // T5: hazard flag tracks slot fill through the WE cycle
    do_reset();
    bus.A1 = 5'd7; bus.A2 = 5'd8;
    bus.v1 = 1'b1; bus.addr1 = 5'd7; bus.data1 = 32'h7777;
    #1;
    chk("t5_busy1_pre", 64'(bus.busy1), 64'd0);
    step();
    bus.v1 = 1'b0;
    #1;
    chk("t5_busy1_slot", 64'(bus.busy1), 64'd1);
    chk("t5_busy2_slot", 64'(bus.busy2), 64'd0);
    step();
    chk("t5_we",         64'(bus.WE),    64'd1);
    chk("t5_busy1_we",   64'(bus.busy1), 64'd1);
    chk("t5_busy2_we",   64'(bus.busy2), 64'd0);
    step();
    chk("t5_busy1_post", 64'(bus.busy1), 64'd0);
    chk("t5_busy2_post", 64'(bus.busy2), 64'd0);

    // T6a: flush discards both slots and a transfer on the flush edge
    do_reset();
    bus.v0 = 1'b1; bus.addr0 = 5'd4; bus.data0 = 32'h44;
    bus.v1 = 1'b1; bus.addr1 = 5'd9; bus.data1 = 32'h99;
    step();
    bus.v1 = 1'b0; bus.addr0 = 5'd5;
    flush = 1'b1;
    step();
    flush = 1'b0; bus.v0 = 1'b0;
    #1;
    chk("t6_we_fl",   64'(bus.WE),   64'd0);
    chk("t6_rdy0_fl", 64'(bus.rdy0), 64'd1);
    chk("t6_rdy1_fl", 64'(bus.rdy1), 64'd1);
    step();
    chk("t6_we_fl2",  64'(bus.WE),   64'd0);

    // T6b: asynchronous reset while a write is on the port
    do_reset();
    bus.v0 = 1'b1; bus.addr0 = 5'd4; bus.data0 = 32'h44;
    bus.v1 = 1'b1; bus.addr1 = 5'd9; bus.data1 = 32'h99;
    step();
    bus.v0 = 1'b0; bus.v1 = 1'b0;
    step();
    chk("t6_we_pre", 64'(bus.WE), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we",   64'(bus.WE),   64'd0);
    chk("t6_rst_a3",   64'(bus.A3),   64'd0);
    chk("t6_rst_wd",   64'(bus.WD),   64'd0);
    chk("t6_rst_rdy0", 64'(bus.rdy0), 64'd1);
    chk("t6_rst_rdy1", 64'(bus.rdy1), 64'd1);
    #1;
    rst_n = 1'b1;
    step();
    chk("t6_post_we1", 64'(bus.WE), 64'd0);
    step();
    chk("t6_post_we2", 64'(bus.WE), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
